// File: rtl/down_counter_parallel_load_borrow_pkg.sv
// Shared definitions for the down counter family: default width, the
// {Load,Count} control encoding and the J/K flip-flop operation codes.
package down_counter_parallel_load_borrow_pkg;

    localparam int WIDTH_DEF = 4;

    // {Load,Count}: Load dominates, so its Count bit is a don't-care.
    localparam logic [1:0] CTL_LD   = 2'b1x;
    localparam logic [1:0] CTL_DEC  = 2'b01;
    localparam logic [1:0] CTL_HOLD = 2'b00;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

endpackage

// File: rtl/down_counter_parallel_load_borrow_if.sv
// Data/control bundle of the down counter; the counter is the slave,
// the surrounding logic (or a bench) is the master.
interface down_counter_parallel_load_borrow_if
#(parameter int WIDTH = down_counter_parallel_load_borrow_pkg::WIDTH_DEF);

    logic [WIDTH-1:0] I;
    logic             Load;
    logic             Count;
    logic             Reload;
    logic [WIDTH-1:0] A;
    logic             B_out;
    logic             Zero;

    modport master (output I, Load, Count, Reload, input A, B_out, Zero);
    modport slave  (input I, Load, Count, Reload, output A, B_out, Zero);

endinterface

// File: rtl/down_counter_jkff.sv
// J/K flip-flop with asynchronous active-low clear; one per counter bit.
module down_counter_jkff
    import down_counter_parallel_load_borrow_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic J,
    input  logic K,
    output logic Q
);

    logic q_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_q <= 1'b0;
        end else begin
            case (jk_op_e'({J, K}))
                JK_HOLD:   q_q <= q_q;
                JK_RESET:  q_q <= 1'b0;
                JK_SET:    q_q <= 1'b1;
                JK_TOGGLE: q_q <= ~q_q;
                default:   q_q <= q_q;
            endcase
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/down_counter_parallel_load_borrow_behavioral.sv
// Golden RTL model of the down counter, port-compatible with the gate-level top.
module down_counter_parallel_load_borrow_behavioral
    import down_counter_parallel_load_borrow_pkg::*;
#(parameter int WIDTH = WIDTH_DEF)
(
    input logic clk,
    input logic rstn,
    down_counter_parallel_load_borrow_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [1:0]       ctl;

    assign ctl = {bus.Load, bus.Count};

    always_comb begin
        // NOTE: default assignment first keeps this block free of inferred latches.
        a_d = a_q;
        if (ctl ==? CTL_LD) begin
            a_d = bus.I;
        end else if (ctl == CTL_DEC) begin
            if (a_q != '0)      a_d = a_q - ONE;
            else if (bus.Reload) a_d = bus.I;
            else                 a_d = '1;
        end else if (ctl == CTL_HOLD) begin
            a_d = a_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) a_q <= '0;
        else       a_q <= a_d;
    end

    assign bus.A     = a_q;
    assign bus.Zero  = (a_q == '0);
    assign bus.B_out = bus.Count & (a_q == '0);

endmodule

// File: rtl/down_counter_parallel_load_borrow.sv
// Gate-level down counter: per-bit J/K steering from and/or/not primitives,
// with parallel load, auto-reload at zero and a combinational borrow out.
module down_counter_parallel_load_borrow
    import down_counter_parallel_load_borrow_pkg::*;
#(parameter int WIDTH = WIDTH_DEF)
(
    input logic clk,
    input logic rstn,
    down_counter_parallel_load_borrow_if.slave bus
);

    logic             load;
    logic             count;
    logic             reload;
    logic [WIDTH-1:0] i_val;

    assign load   = bus.Load;
    assign count  = bus.Count;
    assign reload = bus.Reload;
    assign i_val  = bus.I;

    wire [WIDTH-1:0] a_q;
    // low_zero[b] = all bits below b are zero; low_zero[WIDTH] is the Zero flag.
    wire [WIDTH:0]   low_zero;
    wire             n_load;
    wire             cnt_en;
    wire             rld_zero;
    wire             n_rld_zero;
    wire             rel;
    wire             b_out;

    assign low_zero[0] = 1'b1;

    not u_n_load   (n_load, load);
    and u_cnt_en   (cnt_en, count, n_load);
    and u_rld_zero (rld_zero, reload, low_zero[WIDTH]);
    not u_n_rld    (n_rld_zero, rld_zero);
    and u_rel      (rel, cnt_en, rld_zero);
    and u_b_out    (b_out, count, low_zero[WIDTH]);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        wire n_i;
        wire tgl;
        wire j_ld;
        wire k_ld;
        wire j_rl;
        wire k_rl;
        wire j_d;
        wire k_d;

        assign low_zero[b+1] = ~|a_q[b:0];

        not u_n_i  (n_i, i_val[b]);
        and u_tgl  (tgl, cnt_en, low_zero[b], n_rld_zero);
        and u_j_ld (j_ld, i_val[b], load);
        and u_k_ld (k_ld, n_i, load);
        and u_j_rl (j_rl, i_val[b], rel);
        and u_k_rl (k_rl, n_i, rel);
        or  u_j    (j_d, j_ld, j_rl, tgl);
        or  u_k    (k_d, k_ld, k_rl, tgl);

        down_counter_jkff u_ff (
            .clk  (clk),
            .rstn (rstn),
            .J    (j_d),
            .K    (k_d),
            .Q    (a_q[b])
        );
    end

    assign bus.A     = a_q;
    assign bus.Zero  = low_zero[WIDTH];
    assign bus.B_out = b_out;

endmodule

// File: tb/tb_down_counter_parallel_load_borrow.sv
// Bench for the gate-level down counter against the behavioural model and an
// arithmetic reference: directed vectors, corner sequences, then random traffic.
module tb_down_counter_parallel_load_borrow;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rstn;
    logic         load_r;
    logic         count_r;
    logic         reload_r;
    logic [W-1:0] i_r;

    int n_checks = 0;
    int n_fail   = 0;
    int m_a;

    down_counter_parallel_load_borrow_if #(.WIDTH(W)) s_if ();
    down_counter_parallel_load_borrow_if #(.WIDTH(W)) b_if ();
    down_counter_parallel_load_borrow_if #(.WIDTH(W)) lo_if ();
    down_counter_parallel_load_borrow_if #(.WIDTH(W)) hi_if ();

    assign s_if.I = i_r;  assign s_if.Load = load_r;  assign s_if.Count = count_r;  assign s_if.Reload = reload_r;
    assign b_if.I = i_r;  assign b_if.Load = load_r;  assign b_if.Count = count_r;  assign b_if.Reload = reload_r;
    assign lo_if.I = i_r; assign lo_if.Load = load_r; assign lo_if.Count = count_r; assign lo_if.Reload = reload_r;
    assign hi_if.I = i_r; assign hi_if.Load = load_r; assign hi_if.Count = lo_if.B_out; assign hi_if.Reload = reload_r;

    down_counter_parallel_load_borrow #(.WIDTH(W)) u_dut (.clk(clk), .rstn(rstn), .bus(s_if.slave));
    down_counter_parallel_load_borrow_behavioral #(.WIDTH(W)) u_gold (.clk(clk), .rstn(rstn), .bus(b_if.slave));
    down_counter_parallel_load_borrow #(.WIDTH(W)) u_lo (.clk(clk), .rstn(rstn), .bus(lo_if.slave));
    down_counter_parallel_load_borrow #(.WIDTH(W)) u_hi (.clk(clk), .rstn(rstn), .bus(hi_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the value the counter should hold, from the priority rules.
    always @(posedge clk or negedge rstn) begin
        if (!rstn)         m_a <= 0;
        else if (load_r)   m_a <= int'(i_r);
        else if (count_r)  m_a <= (m_a == 0 && reload_r) ? int'(i_r) : (m_a + MOD - 1) % MOD;
    end

    always @(negedge clk) begin
        check("mon.dut_A",     int'(s_if.A),     m_a);
        check("mon.gold_A",    int'(b_if.A),     m_a);
        check("mon.dut_Zero",  int'(s_if.Zero),  int'(m_a == 0));
        check("mon.gold_Zero", int'(b_if.Zero),  int'(m_a == 0));
        check("mon.dut_Bout",  int'(s_if.B_out), int'(count_r && m_a == 0));
        check("mon.gold_Bout", int'(b_if.B_out), int'(count_r && m_a == 0));
    end

    typedef struct {
        logic         load;
        logic         count;
        logic         reload;
        logic [W-1:0] ival;
        logic [W-1:0] a;
        logic         b;
        logic         z;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // load, count, reload, I -> A, B_out, Zero (after one edge)
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd10, 4'd10, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd3,  4'd3,  1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd3,  4'd2,  1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd3,  4'd1,  1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd3,  4'd0,  1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd3,  4'd15, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 4'd3,  4'd14, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd5,  4'd5,  1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd9,  4'd9,  1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 4'd0,  4'd0,  1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, 4'd2,  4'd2,  1'b0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd2, 4'd1, 1'b0, 1'b0});
            vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd2, 4'd0, 1'b1, 1'b1});
            vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0});
        end
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0,  4'd1,  1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd0,  4'd0,  1'b1, 1'b1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4'd7,  4'd7,  1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4'd7,  4'd7,  1'b0, 1'b0});

        rstn = 1'b0; load_r = 1'b0; count_r = 1'b1; reload_r = 1'b0; i_r = '0;
        @(negedge clk);
        check("reset.A",     int'(s_if.A),     0);
        check("reset.Zero",  int'(s_if.Zero),  1);
        check("reset.B_out", int'(s_if.B_out), 1);
        #1;
        rstn = 1'b1;
        count_r = 1'b0;

        foreach (vecs[k]) begin
            load_r = vecs[k].load; count_r = vecs[k].count;
            reload_r = vecs[k].reload; i_r = vecs[k].ival;
            @(negedge clk);
            check($sformatf("vec%0d.A", k),     int'(s_if.A),     int'(vecs[k].a));
            check($sformatf("vec%0d.B_out", k), int'(s_if.B_out), int'(vecs[k].b));
            check($sformatf("vec%0d.Zero", k),  int'(s_if.Zero),  int'(vecs[k].z));
            #1;
        end

        // Asynchronous reset mid-count, then cascade from 8'h00.
        load_r = 1'b1; count_r = 1'b0; reload_r = 1'b0; i_r = 4'd7;
        @(negedge clk);
        check("async.pre_A", int'(s_if.A), 7);
        #1;
        load_r = 1'b0; count_r = 1'b1;
        #1;
        rstn = 1'b0;
        #1;
        check("async.A_before_edge", int'(s_if.A),     0);
        check("async.gold_A",        int'(b_if.A),     0);
        check("async.Zero",          int'(s_if.Zero),  1);
        check("async.B_out",         int'(s_if.B_out), 1);
        check("casc.reset_value",    int'({hi_if.A, lo_if.A}), 0);
        check("casc.hi_count",       int'(lo_if.B_out), 1);
        @(negedge clk);
        check("async.held_in_reset", int'(s_if.A), 0);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("async.wrap_after_release", int'(s_if.A),     15);
        check("async.no_borrow_history",  int'(s_if.B_out), 0);
        check("casc.wrap_ff",             int'({hi_if.A, lo_if.A}), 8'hFF);
        #1;
        @(negedge clk);
        check("casc.next_fe",             int'({hi_if.A, lo_if.A}), 8'hFE);
        #1;

        for (int n = 0; n < 400; n++) begin
            load_r   = ($urandom_range(0, 9) == 0);
            count_r  = ($urandom_range(0, 3) != 0);
            reload_r = $urandom_range(0, 1) == 1;
            i_r      = W'($urandom_range(0, MOD - 1));
            if ($urandom_range(0, 49) == 0) begin
                rstn = 1'b0;
                #2;
                rstn = 1'b1;
            end
            @(negedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
